mdu_alu_ctrl: RTL and testbench
===============================

# mdu_alu_ctrl

Execute-stage control block for the pipelined MIPS core. It replaces the purely combinational ALU control decode with a parametrised version that also covers shifts, unsigned compare and HI/LO moves. It owns an iterative multiply/divide unit (MDU) with HI/LO registers, and asserts a stall to the hazard unit while the MDU is busy and the instruction in EX needs it.

## Interface
- WIDTH, 32: datapath and HI/LO width; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- valid_in  in  1  EX holds a valid instruction.
- alu_op  in  3  from main control: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 xor, 110 slt, 111 sltu.
- funct  in  6  instruction[5:0].
- rs_val, rt_val  in  WIDTH  forwarded operands.
- alu_control  out  4  ALU opcode.
- illegal  out  1  R-type with undecoded funct.
- stall  out  1  hold IF/ID/EX; this instruction is re-presented.
- busy  out  1  MDU iterating.
- hi, lo  out  WIDTH  HI/LO registers.
- mdu_result  out  WIDTH  hi for mfhi, lo for mflo, else 0.
- div_by_zero  out  1  one-cycle pulse.

## Operation
- ALU codes: and 0000, or 0001, add 0010, xor 0011, sub 0110, slt 0111, sltu 1000, sll 1001, srl 1010, sra 1011, nor 1100, pass-MDU 1111.
- alu_control is combinational. reset high forces 0000 and illegal=0.
- Non-R alu_op values map directly to their code.
- R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x10/0x12 pass-MDU.
  - 0x18/0x19/0x1A/0x1B (mult/multu/div/divu) and 0x11/0x13 (mthi/mtlo) → add, with ALU result unused.
  - Any other funct → add, illegal=1 (only when valid_in=1).
- An MDU op is valid_in && alu_op==010 && funct ∈ {0x10–0x13, 0x18–0x1B}.
- stall = MDU op && busy. Combinational. An MDU op is accepted only on a cycle with stall=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE + accepted mult/multu → MUL. Latch magnitudes (signed) or raw operands (unsigned), latch result sign, load counter with WIDTH.
  - IDLE + accepted div/divu, rt≠0 → DIV. Restoring division on magnitudes, counter WIDTH.
  - IDLE + accepted div/divu, rt==0 → stay IDLE. Next edge: lo=all ones, hi=rs_val, div_by_zero pulses for the following cycle.
  - MUL/DIV: one shift-add or shift-subtract per cycle. Counter decrements; at 1 → FIX.
  - FIX: apply signs, then write hi/lo and go to IDLE.
    - mult: negate the 2·WIDTH product if the sign bit is set.
    - div: quotient negated if sign(rs)≠sign(rt); remainder takes sign(rs).
- Signed most-negative ÷ −1: lo=100…0, hi=0 (wraps, no flag).
- mthi/mtlo accepted in IDLE write hi/lo at that edge. mfhi/mflo read the current register.
- A new MDU op during busy stalls. Non-MDU instructions are never stalled and proceed while the MDU iterates.

## Timing
- Reset values: hi=lo=0, busy=0, div_by_zero=0, state IDLE, counter 0. stall=0 while reset is high.
- Reset mid-iteration aborts the operation; hi/lo clear to 0 on that edge.
- mult/div are accepted at edge E. busy=1 from E to E+WIDTH+1. hi/lo are valid after edge E+WIDTH+1, i.e. WIDTH+1 busy cycles.
- An mfhi/mflo issued right after mult stalls WIDTH+1 cycles, then reads the new value in the same cycle that busy falls.
- Divide by zero: busy never rises; the flag is high exactly one cycle after the accept edge.
- Back-to-back: a second mult presented in the cycle busy falls is accepted with zero bubble.

## Test plan
- Decode sweep: every alu_op and every listed funct, plus funct 0x3F → codes above. 0x3F with valid_in=1 gives illegal=1.
- WIDTH=32, mult rs=−3, rt=5 → busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- div rs=7, rt=−2 → lo=0xFFFFFFFD, hi=1. divu 0x80000000/3 → lo=0x2AAAAAAA, hi=2. div 0x80000000/−1 → lo=0x80000000, hi=0.
- mult followed immediately by mflo → stall=1 for 33 cycles, then mdu_result=lo_new with stall=0. An add in the same window never stalls.
- divu rs=9, rt=0 → no busy, lo=0xFFFFFFFF, hi=9, div_by_zero one-cycle pulse. mthi 0x1234 in IDLE → hi=0x1234 next cycle.
- reset at cycle 10 of a mult → next cycle state IDLE, busy=0, hi=lo=0. A following mflo is not stalled and returns 0.

Source files
------------

// File: rtl/mdu_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_alu_ctrl
// Purpose  : Execute-stage control for the pipelined MIPS core. Decodes the
//            ALU opcode from main-control alu_op and the R-type funct field,
//            and owns an iterative multiply/divide unit with HI/LO registers.
//            A stall is raised while the MDU iterates and the instruction in
//            EX needs it.
// Ports    : clk_i, reset_i (sync, active-high)
//            valid_in_i, alu_op_i[2:0], funct_i[5:0], rs_val_i, rt_val_i
//            alu_control_o[3:0], illegal_o, stall_o, busy_o
//            hi_o, lo_o, mdu_result_o, div_by_zero_o
// Revision : 1.0  initial release
// ============================================================================
module mdu_alu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_in_i,
    input  logic [2:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    output logic [3:0]       alu_control_o,
    output logic             illegal_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mdu_result_o,
    output logic             div_by_zero_o
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MDU  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Shared accumulator: {partial product} for MUL, {remainder, quotient} for DIV.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;      // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;      // product / quotient sign
    logic                 rneg_q, rneg_d;    // remainder sign
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    // ------------------------------------------------------------------
    // ALU decode
    // ------------------------------------------------------------------
    logic w_is_r;
    assign w_is_r = (alu_op_i == 3'b010);

    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (alu_op_i)
            3'b000: alu_control_o = ALU_ADD;
            3'b001: alu_control_o = ALU_SUB;
            3'b011: alu_control_o = ALU_AND;
            3'b100: alu_control_o = ALU_OR;
            3'b101: alu_control_o = ALU_XOR;
            3'b110: alu_control_o = ALU_SLT;
            3'b111: alu_control_o = ALU_SLTU;
            default: begin
                case (funct_i)
                    6'h20: alu_control_o = ALU_ADD;
                    6'h22: alu_control_o = ALU_SUB;
                    6'h24: alu_control_o = ALU_AND;
                    6'h25: alu_control_o = ALU_OR;
                    6'h26: alu_control_o = ALU_XOR;
                    6'h27: alu_control_o = ALU_NOR;
                    6'h2A: alu_control_o = ALU_SLT;
                    6'h2B: alu_control_o = ALU_SLTU;
                    6'h00: alu_control_o = ALU_SLL;
                    6'h02: alu_control_o = ALU_SRL;
                    6'h03: alu_control_o = ALU_SRA;
                    6'h10, 6'h12: alu_control_o = ALU_MDU;
                    // MDU writers: ALU result is ignored downstream.
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: alu_control_o = ALU_ADD;
                    default: begin
                        alu_control_o = ALU_ADD;
                        illegal_o     = valid_in_i;
                    end
                endcase
            end
        endcase
        if (reset_i) begin
            alu_control_o = ALU_AND;
            illegal_o     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // MDU issue logic
    // ------------------------------------------------------------------
    logic w_mdu_funct, w_mdu_op, w_busy, w_accept;
    // 0x10-0x13 and 0x18-0x1B share funct[5:2] patterns 0100 / 0110.
    assign w_mdu_funct = (funct_i[5:2] == 4'b0100) || (funct_i[5:2] == 4'b0110);
    assign w_mdu_op    = valid_in_i && w_is_r && w_mdu_funct;
    assign w_busy      = (state_q != S_IDLE);
    assign w_accept    = w_mdu_op && !w_busy;

    assign stall_o       = w_mdu_op && w_busy && !reset_i;
    assign busy_o        = w_busy;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

    always_comb begin
        mdu_result_o = '0;
        if (w_is_r && funct_i == 6'h10) mdu_result_o = hi_q;
        if (w_is_r && funct_i == 6'h12) mdu_result_o = lo_q;
    end

    // Signed ops (mult, div) have funct[0]=0; unsigned variants have funct[0]=1.
    logic             w_signed, w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag, w_rt_mag;
    assign w_signed = !funct_i[0];
    assign w_rs_neg = w_signed && rs_val_i[WIDTH-1];
    assign w_rt_neg = w_signed && rt_val_i[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -rs_val_i : rs_val_i;
    assign w_rt_mag = w_rt_neg ? -rt_val_i : rt_val_i;

    // One shift-add multiply step: the upper half carries into a spare bit,
    // which becomes the MSB after the right shift.
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    assign w_addend = acc_q[0] ? opd_q : {WIDTH{1'b0}};
    assign w_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // One restoring divide step on {remainder, dividend}.
    logic [WIDTH:0] w_shifted, w_diff;
    logic           w_ge;
    assign w_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, opd_q});
    assign w_diff    = w_shifted - {1'b0, opd_q};

    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quo_neg, w_rem_neg;
    assign w_prod_neg = -acc_q;
    assign w_quo_neg  = -acc_q[WIDTH-1:0];
    assign w_rem_neg  = -acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (funct_i)
                        6'h11: hi_d = rs_val_i;
                        6'h13: lo_d = rs_val_i;
                        6'h18, 6'h19: begin
                            state_d  = S_MUL;
                            acc_d    = {{WIDTH{1'b0}}, w_rs_mag};
                            opd_d    = w_rt_mag;
                            neg_d    = w_rs_neg ^ w_rt_neg;
                            is_div_d = 1'b0;
                            cnt_d    = CNT_W'(WIDTH);
                        end
                        6'h1A, 6'h1B: begin
                            if (rt_val_i == '0) begin
                                lo_d  = '1;
                                hi_d  = rs_val_i;
                                dbz_d = 1'b1;
                            end else begin
                                state_d  = S_DIV;
                                acc_d    = {{WIDTH{1'b0}}, w_rs_mag};
                                opd_d    = w_rt_mag;
                                neg_d    = w_rs_neg ^ w_rt_neg;
                                rneg_d   = w_rs_neg;
                                is_div_d = 1'b1;
                                cnt_d    = CNT_W'(WIDTH);
                            end
                        end
                        default: ;  // mfhi/mflo only read
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {w_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {(w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], w_ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q  ? w_quo_neg : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? w_rem_neg : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_q ? w_prod_neg : acc_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_alu_ctrl
// Purpose  : Self-checking bench for mdu_alu_ctrl. MDU results are pushed to
//            a scoreboard at issue and popped by a monitor on completion.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_alu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   alu_control;
    logic         illegal, stall, busy, div_by_zero;
    logic [W-1:0] hi, lo, mdu_result;

    mdu_alu_ctrl #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .valid_in_i    (valid_in),
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .rs_val_i      (rs_val),
        .rt_val_i      (rt_val),
        .alu_control_o (alu_control),
        .illegal_o     (illegal),
        .stall_o       (stall),
        .busy_o        (busy),
        .hi_o          (hi),
        .lo_o          (lo),
        .mdu_result_o  (mdu_result),
        .div_by_zero_o (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: an MDU result appears when busy falls or div_by_zero pulses.
    always @(negedge clk) begin
        if (!reset && ((prev_busy && !busy) || div_by_zero)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: result with empty scoreboard hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_hi", hi, mon_e.hi);
                chk("sb_lo", lo, mon_e.lo);
                chk("sb_dbz", {31'b0, div_by_zero}, {31'b0, mon_e.dbz});
            end
        end
        prev_busy <= busy;
    end

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = d;
        sb_q.push_back(e);
    endtask

    task automatic present(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_in = 1'b1; alu_op = 3'b010; funct = fn; rs_val = a; rt_val = b;
    endtask

    task automatic idle_bus();
        valid_in = 1'b0; alu_op = 3'b000; funct = 6'h00; rs_val = '0; rt_val = '0;
    endtask

    // Entered just after a posedge; returns just after the accept posedge.
    task automatic issue(input string name, input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        present(fn, a, b);
        push(eh, el, 1'b0);
        @(negedge clk);
        chk({name, "_no_stall_at_issue"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 60);
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: busy still %b want 0", name, busy);
        end
        @(posedge clk); #1;
    endtask

    // Counts negedges with stall high; leaves time at the first stall-free negedge.
    task automatic count_stall(output int k);
        k = 0;
        @(negedge clk);
        while (stall && k < 60) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic dec(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] code);
        alu_op = op; funct = fn;
        #1;
        chk($sformatf("decode_op%0d_fn%h", op, fn), {28'b0, alu_control}, {28'b0, code});
        chk($sformatf("illegal_op%0d_fn%h", op, fn), {31'b0, illegal}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        valid_in = 1'b1; alu_op = 3'b010; funct = 6'h3F; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_control", {28'b0, alu_control}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_bus();

        // Decode sweep with valid_in low so nothing reaches the MDU.
        dec(3'b000, 6'h3F, 4'b0010);
        dec(3'b001, 6'h3F, 4'b0110);
        dec(3'b011, 6'h3F, 4'b0000);
        dec(3'b100, 6'h3F, 4'b0001);
        dec(3'b101, 6'h3F, 4'b0011);
        dec(3'b110, 6'h3F, 4'b0111);
        dec(3'b111, 6'h3F, 4'b1000);
        dec(3'b010, 6'h20, 4'b0010);
        dec(3'b010, 6'h22, 4'b0110);
        dec(3'b010, 6'h24, 4'b0000);
        dec(3'b010, 6'h25, 4'b0001);
        dec(3'b010, 6'h26, 4'b0011);
        dec(3'b010, 6'h27, 4'b1100);
        dec(3'b010, 6'h2A, 4'b0111);
        dec(3'b010, 6'h2B, 4'b1000);
        dec(3'b010, 6'h00, 4'b1001);
        dec(3'b010, 6'h02, 4'b1010);
        dec(3'b010, 6'h03, 4'b1011);
        dec(3'b010, 6'h10, 4'b1111);
        dec(3'b010, 6'h12, 4'b1111);
        dec(3'b010, 6'h18, 4'b0010);
        dec(3'b010, 6'h19, 4'b0010);
        dec(3'b010, 6'h1A, 4'b0010);
        dec(3'b010, 6'h1B, 4'b0010);
        dec(3'b010, 6'h11, 4'b0010);
        dec(3'b010, 6'h13, 4'b0010);
        dec(3'b010, 6'h3F, 4'b0010);
        valid_in = 1'b1; alu_op = 3'b010; funct = 6'h3F;
        #1;
        chk("illegal_3F_valid", {31'b0, illegal}, 32'd1);
        chk("decode_3F_valid", {28'b0, alu_control}, 32'd2);
        idle_bus();
        @(posedge clk); #1;

        // mthi / mtlo
        present(6'h11, 32'h0000_1234, '0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("mthi_hi", hi, 32'h0000_1234);
        @(posedge clk); #1;
        present(6'h13, 32'h0000_5678, '0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h0000_5678);
        @(posedge clk); #1;

        // mult -3*5 followed immediately by mflo
        issue("mult_m3x5", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        present(6'h12, '0, '0);
        count_stall(k);
        chk("mflo_stall_cycles", k, 32'd33);
        chk("mflo_result", mdu_result, 32'hFFFF_FFF1);
        chk("mflo_busy_low", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        idle_bus();

        // multu with non-MDU instructions flowing during iteration
        issue("multu", 6'h19, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
        valid_in = 1'b1; alu_op = 3'b000;
        @(negedge clk);
        chk("add_no_stall", {31'b0, stall}, 32'd0);
        chk("add_during_busy", {31'b0, busy}, 32'd1);
        alu_op = 3'b010; funct = 6'h20;
        #1;
        chk("radd_no_stall", {31'b0, stall}, 32'd0);
        chk("radd_code", {28'b0, alu_control}, 32'd2);
        idle_bus();
        wait_done("multu");

        // Divides
        issue("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        wait_done("div_7_m2");
        issue("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_m7_2");
        issue("divu_big", 6'h1B, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);
        wait_done("divu_big");
        issue("div_minneg", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done("div_minneg");

        // Divide by zero
        present(6'h1B, 32'd9, 32'd0);
        push(32'd9, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("dbz_no_busy", {31'b0, busy}, 32'd0);
        chk("dbz_pulse_high", {31'b0, div_by_zero}, 32'd1);
        @(negedge clk);
        chk("dbz_pulse_low", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back mult: the second is accepted as busy falls
        issue("b2b_first", 6'h18, 32'd6, 32'd7, 32'd0, 32'd42);
        present(6'h18, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        push(32'd0, 32'd16, 1'b0);
        count_stall(k);
        chk("b2b_stall_cycles", k, 32'd33);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("b2b_accepted", {31'b0, busy}, 32'd1);
        wait_done("b2b_second");

        // Reset in the middle of a mult
        present(6'h18, 32'd100, 32'd100);
        @(posedge clk); #1;
        idle_bus();
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        present(6'h12, '0, '0);
        #1;
        chk("rst_stall_low", {31'b0, stall}, 32'd0);
        chk("rst_force_code", {28'b0, alu_control}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_mflo_stall", {31'b0, stall}, 32'd0);
        chk("post_rst_mflo", mdu_result, 32'd0);
        @(posedge clk); #1;
        idle_bus();
        repeat (2) @(posedge clk);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: %0d entries remain want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
